// File: rtl/sar_compare_search.sv
// Successive-approximation search controller driving a cascadable comparator's B operand.
// One trial per cycle, MSB first; recovers the comparator's A operand in at most WIDTH compares.
module sar_compare_search #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lt,
  input  logic             eq,
  input  logic             gt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       steps,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    TRY,
    DONE
  } state_t;

  localparam logic [3:0] MSB = 4'(WIDTH - 1);

  state_t           state;
  logic [3:0]       idx;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] next_mask;
  logic [WIDTH-1:0] prefix;
  logic             one_hot;

  always_comb begin
    bit_mask  = WIDTH'(1) << idx;
    next_mask = bit_mask >> 1;
    prefix    = trial & ~bit_mask;
    // Odd parity of the three flags, excluding the all-set case, is exactly one-hot.
    one_hot   = (lt ^ eq ^ gt) & ~(lt & eq & gt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      trial  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      steps  <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= TRY;
            trial <= WIDTH'(1) << MSB;
            idx   <= MSB;
            steps <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        TRY: begin
          steps <= steps + 4'd1;
          if (!one_hot || (gt && idx == 4'd0)) begin
            err    <= 1'b1;
            result <= '0;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            trial  <= '0;
          end else if (eq) begin
            result <= trial;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            trial  <= '0;
          end else if (idx == 4'd0) begin
            // Only lt can reach here at bit 0: the current bit is cleared for good.
            result <= prefix;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            trial  <= '0;
          end else begin
            trial <= gt ? (trial | next_mask) : (prefix | next_mask);
            idx   <= idx - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_compare_search.sv
// Randomised and directed checks of sar_compare_search against an arithmetic model
// of binary search over an unknown comparator operand.
module tb_sar_compare_search;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         lt, eq, gt;
  logic [W-1:0] trial, result;
  logic         busy, done, err;
  logic [3:0]   steps;

  int unsigned  a_val = 0;
  int           mode = 0;   // 0 honest comparator, 1 lt&gt, 2 always gt, 3 no flag
  int           n_vec = 0;
  int           n_err = 0;

  sar_compare_search #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .lt(lt), .eq(eq), .gt(gt),
    .trial(trial), .busy(busy), .done(done), .result(result),
    .steps(steps), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    lt = 1'b0; eq = 1'b0; gt = 1'b0;
    case (mode)
      0: begin
        lt = a_val < int'(trial);
        eq = a_val == int'(trial);
        gt = a_val > int'(trial);
      end
      1: begin lt = 1'b1; gt = 1'b1; end
      2: gt = 1'b1;
      default: ;
    endcase
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (A=%0d mode=%0d)", tag, got, exp, a_val, mode);
    end
  endtask

  function automatic int unsigned tz(input int unsigned a);
    int unsigned n = 0;
    while (n < W && a[n] == 1'b0) n++;
    return n;
  endfunction

  // k-th trial: bits of A above the probed bit, with the probed bit set.
  function automatic int unsigned exp_trial(input int unsigned a, input int m, input int unsigned k);
    int unsigned b;
    if (k >= W) return 0;
    b = W - 1 - k;
    if (m == 2) return ((1 << W) - 1) & ~((1 << b) - 1);
    return ((a >> (b + 1)) << (b + 1)) | (1 << b);
  endfunction

  function automatic int unsigned exp_steps(input int unsigned a, input int m);
    case (m)
      0: return (a == 0) ? W : W - tz(a);
      2: return W;
      default: return 1;
    endcase
  endfunction

  task automatic run_search(input int unsigned a, input int m, input bit poke);
    int unsigned k = 0;
    @(negedge clk);
    a_val = a; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && k < W + 2) begin
      check("trial", trial, exp_trial(a, m, k));
      check("done_low", done, 0);
      start = (poke && k == 0);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    check("ntrials", k, exp_steps(a, m));
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("steps", steps, exp_steps(a, m));
    check("err", err, (m == 0) ? 0 : 1);
    check("result", result, (m == 0) ? a : 0);
    check("trial_idle", trial, 0);
  endtask

  initial begin
    int unsigned k;
    int unsigned r;
    repeat (2) @(negedge clk);
    check("rst_trial", trial, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_steps", steps, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    run_search(5, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("hold_result", result, 5);
    check("hold_done", done, 1);
    run_search(4, 0, 1'b0);
    run_search(0, 0, 1'b0);
    run_search(7, 0, 1'b0);
    run_search(3, 0, 1'b0);
    run_search(6, 1, 1'b0);
    run_search(6, 2, 1'b0);
    run_search(6, 3, 1'b0);
    run_search(5, 0, 1'b1);
    run_search(4, 0, 1'b1);

    // Reset mid-search while trial is 6.
    @(negedge clk);
    a_val = 7; mode = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (trial != 6 && k < W + 2) begin
      k++;
      @(negedge clk);
    end
    check("reach6", trial, 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_trial", trial, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_steps", steps, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    check("idle_stays", busy, 0);

    for (int unsigned v = 0; v < (1 << W); v++) run_search(v, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_search($urandom_range(0, (1 << W) - 1), (r < 7) ? 0 : int'($urandom_range(1, 3)),
                 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sar_compare_search.md
Name: sar_compare_search

Overview:
- Successive-approximation search controller; the initiator side of the 3-bit cascadable comparator interface.
- Drives the comparator B operand with trial values and consumes its lt/eq/gt result, one trial per cycle, MSB first.
- Recovers the unknown value on comparator input A in at most WIDTH compares.
- Used to digitise or identify an unknown operand (threshold search, value recovery) in the comparator labs.

Parameters:
WIDTH, 3, operand width in bits; legal range 2..15; trial and result are WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new search; sampled in IDLE or DONE only
lt  input  1  comparator result: A < trial
eq  input  1  comparator result: A == trial (comparator cascade inputs tied e=1, l=0, g=0 externally)
gt  input  1  comparator result: A > trial
trial  output  WIDTH  value driven to comparator B operand
busy  output  1  high while in TRY
done  output  1  high while in DONE (level, not pulse)
result  output  WIDTH  recovered value of A; valid when done=1
steps  output  4  number of compares used by the last search
err  output  1  protocol/consistency error on last search; valid when done=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, trial=0, busy=0, done=0, result=0, steps=0, err=0.
- Reset has priority over all other inputs, including mid-search; any search in progress is abandoned.
- Comparator is combinational. lt/eq/gt are sampled on the same edge that ends the cycle in which trial is presented.
- States: IDLE, TRY, DONE.
- IDLE/DONE, start=1 on an edge:
  - go to TRY; trial <= 1<<(WIDTH-1); bit index i <= WIDTH-1.
  - steps <= 0, err <= 0, done <= 0, busy <= 1.
  - result keeps its old value until the new search completes.
- TRY, every edge:
  - steps increments.
  - Let p = trial with bit i cleared (the current prefix).
  - Flags not exactly one-hot (none set, or more than one set): err<=1, result<=0, go DONE.
  - eq=1: result<=trial, go DONE (early termination).
  - gt=1 and i>0: trial <= trial | (1<<(i-1)); i <= i-1 (bit i kept).
  - lt=1 and i>0: trial <= p | (1<<(i-1)); i <= i-1 (bit i cleared).
  - lt=1 and i==0: result<=p, go DONE.
  - gt=1 and i==0: impossible for a consistent A. err<=1, result<=0, go DONE.
- Entering DONE: busy<=0, done<=1, trial<=0.
- DONE holds result, steps and err until start or rst.
- start while in TRY is ignored.
- Latency: start sampled at edge 0; done high after edge k, where k = steps and 1 <= k <= WIDTH.
- trial is 0 in IDLE and DONE.
- If A changes mid-search, the behaviour is the rules above; no extra detection beyond the gt-at-bit-0 check.

Test Plan:
1. WIDTH=3, bench comparator models A=5 -> trials 4(gt), 6(lt), 5(eq); done=1 three edges after start; result=5, steps=3, err=0.
2. A=4 -> trial 4 answers eq; done after 1 edge, result=4, steps=1. A=0 -> trials 4, 2, 1 all lt; result=0, steps=3.
3. A=7 -> trials 4, 6, 7 (eq); result=7, steps=3. Then pulse start in DONE with A=3 -> trials 4, 2, 3; result=3, done falls the edge after start.
4. Force lt=gt=1 on first trial -> next edge: done=1, err=1, result=0, steps=1. Force gt=1 at every trial -> trials 4, 6, 7, then err=1 at i=0, steps=3.
5. Assert rst while trial=6 mid-search -> next edge: all outputs 0, state IDLE. Pulse start in TRY -> ignored; trial sequence unchanged.
6. Sweep A=0..7 back-to-back starts -> result==A, err=0, steps<=3 for every value.
